// File: rtl/gpo_pad_tx.sv
// gpo_pad_tx: serial transmitter driving a general-purpose output pad.
// Accepts parallel words over a valid/ready handshake and shifts them onto the pad
// at a programmable bit period.
// OE_O rises GUARD cycles before the first bit and falls GUARD cycles after the last bit.
// Back-to-back words, handed over in the final cycle of a frame, follow with no gap.
//
// Ports:
//   CLK_I        core clock
//   RST_I        asynchronous reset, active-high
//   EN_I         block enable; low aborts any frame in flight
//   DIV_I        bit period minus 1
//   LSB_FIRST_I  1 = LSB shifted first, 0 = MSB first
//   IDLE_I       level driven on DO_O during lead/lag
//   DS_I         pad drive strength for the next frame
//   DATA_I       word to transmit
//   VALID_I      DATA_I valid
//   READY_O      block can accept a word (combinational)
//   DO_O         pad data out
//   OE_O         pad output enable
//   DS_O         pad drive strength
//   BUSY_O       frame in progress
//   DONE_O       one-cycle pulse per completed frame
module gpo_pad_tx #(
   parameter int DW    = 8,
   parameter int DIV_W = 8,
   parameter int GUARD = 2
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   input  logic             EN_I,
   input  logic [DIV_W-1:0] DIV_I,
   input  logic             LSB_FIRST_I,
   input  logic             IDLE_I,
   input  logic [1:0]       DS_I,
   input  logic [DW-1:0]    DATA_I,
   input  logic             VALID_I,
   output logic             READY_O,
   output logic             DO_O,
   output logic             OE_O,
   output logic [1:0]       DS_O,
   output logic             BUSY_O,
   output logic             DONE_O
);

   localparam int BW = (DW > 1) ? $clog2(DW) : 1;
   localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
   localparam logic [GW-1:0] GRD_LAST = GW'((GUARD > 0) ? GUARD - 1 : 0);

   typedef enum logic [1:0] {StIdle, StLead, StShift, StLag} state_e;

   state_e           state_q, state_d;
   logic [GW-1:0]    gcnt_q, gcnt_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             idle_q, idle_d;
   logic [DW-1:0]    sh_q, sh_d;
   logic             do_q, do_d;
   logic             oe_q, oe_d;
   logic [1:0]       ds_q, ds_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             last_cycle;
   logic             xfer;
   logic [DW-1:0]    word;

   // Words are normalised to LSB-first at load so the shifter only ever moves one way.
   function automatic logic [DW-1:0] order(input logic [DW-1:0] w, input logic lsb);
      logic [DW-1:0] r;
      r = {<<{w}};
      return lsb ? w : r;
   endfunction

   assign last_cycle = (state_q == StShift) && (div_cnt_q == div_q) && (bit_cnt_q == BIT_LAST);
   assign READY_O    = EN_I && !RST_I && ((state_q == StIdle) || last_cycle);
   assign xfer       = VALID_I && READY_O;

   always_comb begin
      state_d   = state_q;
      gcnt_d    = gcnt_q;
      div_cnt_d = div_cnt_q;
      bit_cnt_d = bit_cnt_q;
      div_d     = div_q;
      idle_d    = idle_q;
      sh_d      = sh_q;
      do_d      = do_q;
      oe_d      = oe_q;
      ds_d      = ds_q;
      done_d    = 1'b0;
      word      = order(DATA_I, LSB_FIRST_I);

      if (!EN_I) begin
         // Abort: frame discarded, no DONE pulse; idle state is left untouched.
         if (state_q != StIdle) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            do_d    = 1'b0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (xfer) begin
                  div_d     = DIV_I;
                  idle_d    = IDLE_I;
                  ds_d      = DS_I;
                  oe_d      = 1'b1;
                  gcnt_d    = '0;
                  div_cnt_d = '0;
                  bit_cnt_d = '0;
                  if (GUARD > 0) begin
                     state_d = StLead;
                     do_d    = IDLE_I;
                     sh_d    = word;
                  end else begin
                     state_d = StShift;
                     do_d    = word[0];
                     sh_d    = word >> 1;
                  end
               end
            end
            StLead: begin
               if (gcnt_q == GRD_LAST) begin
                  state_d   = StShift;
                  gcnt_d    = '0;
                  div_cnt_d = '0;
                  bit_cnt_d = '0;
                  do_d      = sh_q[0];
                  sh_d      = sh_q >> 1;
               end else begin
                  gcnt_d = gcnt_q + 1'b1;
               end
            end
            StShift: begin
               if (div_cnt_q == div_q) begin
                  div_cnt_d = '0;
                  if (bit_cnt_q == BIT_LAST) begin
                     done_d    = 1'b1;
                     bit_cnt_d = '0;
                     if (xfer) begin
                        // Chained word: first bit and new drive strength land together.
                        div_d  = DIV_I;
                        idle_d = IDLE_I;
                        ds_d   = DS_I;
                        do_d   = word[0];
                        sh_d   = word >> 1;
                     end else if (GUARD > 0) begin
                        state_d = StLag;
                        gcnt_d  = '0;
                        do_d    = idle_q;
                     end else begin
                        state_d = StIdle;
                        oe_d    = 1'b0;
                        do_d    = 1'b0;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                     do_d      = sh_q[0];
                     sh_d      = sh_q >> 1;
                  end
               end else begin
                  div_cnt_d = div_cnt_q + 1'b1;
               end
            end
            StLag: begin
               if (gcnt_q == GRD_LAST) begin
                  state_d = StIdle;
                  gcnt_d  = '0;
                  oe_d    = 1'b0;
                  do_d    = 1'b0;
               end else begin
                  gcnt_d = gcnt_q + 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               oe_d    = 1'b0;
               do_d    = 1'b0;
            end
         endcase
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q   <= StIdle;
         gcnt_q    <= '0;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         div_q     <= '0;
         idle_q    <= 1'b0;
         sh_q      <= '0;
         do_q      <= 1'b0;
         oe_q      <= 1'b0;
         ds_q      <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gcnt_q    <= gcnt_d;
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         div_q     <= div_d;
         idle_q    <= idle_d;
         sh_q      <= sh_d;
         do_q      <= do_d;
         oe_q      <= oe_d;
         ds_q      <= ds_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign DO_O   = do_q;
   assign OE_O   = oe_q;
   assign DS_O   = ds_q;
   assign BUSY_O = busy_q;
   assign DONE_O = done_q;

endmodule

// File: tb/tb_gpo_pad_tx.sv
// tb_gpo_pad_tx: bench for gpo_pad_tx (DW=8, DIV_W=8, GUARD=2).
// A timeline model predicts every output cycle by cycle from the accepted words;
// directed scenarios add literal expectations on top of it.
module tb_gpo_pad_tx;

   localparam int G = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] div;
   logic       lsb;
   logic       idle;
   logic [1:0] ds;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       dout;
   logic       oe;
   logic [1:0] dso;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   gpo_pad_tx #(.DW(8), .DIV_W(8), .GUARD(G)) dut (
      .CLK_I(clk), .RST_I(rst), .EN_I(en), .DIV_I(div), .LSB_FIRST_I(lsb),
      .IDLE_I(idle), .DS_I(ds), .DATA_I(data), .VALID_I(valid), .READY_O(ready),
      .DO_O(dout), .OE_O(oe), .DS_O(dso), .BUSY_O(busy), .DONE_O(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- timeline model ----------------
   typedef struct {
      bit       d;
      bit       oe;
      bit [1:0] ds;
      bit       done;
      bit       busy;
      bit       last;
   } ent_t;

   ent_t q[$];
   ent_t cur = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};

   function automatic ent_t mk(bit d, bit o, bit [1:0] s, bit b, bit l);
      ent_t e;
      e.d = d; e.oe = o; e.ds = s; e.done = 1'b0; e.busy = b; e.last = l;
      return e;
   endfunction

   function automatic bit m_ready();
      return !rst && en && (!cur.busy || cur.last);
   endfunction

   always @(posedge clk or posedge rst) begin : model
      ent_t nx;
      bit   was_last;
      logic [7:0] w;
      bit   b;
      if (rst) begin
         q.delete();
         cur = mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      end else if (cur.busy && !en) begin
         q.delete();
         cur = mk(1'b0, 1'b0, cur.ds, 1'b0, 1'b0);
      end else begin
         was_last = cur.last;
         if (valid && m_ready()) begin
            if (cur.busy) q.delete();  // chained word replaces the lag
            else for (int i = 0; i < G; i++) q.push_back(mk(idle, 1'b1, ds, 1'b1, 1'b0));
            w = data;
            for (int i = 0; i < 8; i++) begin
               b = lsb ? w[0] : w[7];
               w = lsb ? (w >> 1) : (w << 1);
               for (int k = 0; k <= int'(div); k++)
                  q.push_back(mk(b, 1'b1, ds, 1'b1, (i == 7) && (k == int'(div))));
            end
            for (int i = 0; i < G; i++) q.push_back(mk(idle, 1'b1, ds, 1'b1, 1'b0));
         end
         if (q.size() > 0) nx = q.pop_front();
         else nx = mk(1'b0, 1'b0, cur.ds, 1'b0, 1'b0);
         nx.done = was_last;
         cur = nx;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("do", dout, cur.d);
      chk("oe", oe, cur.oe);
      chk("ds", dso, cur.ds);
      chk("done", done, cur.done);
      chk("busy", busy, cur.busy);
      chk("ready", ready, m_ready());
   end

   // ---------------- recorder for directed scenarios ----------------
   bit rec = 1'b0;
   bit dq[$];
   int oe_cnt, done_cnt, fall_cnt;
   bit prev_oe = 1'b0;

   always @(negedge clk) begin
      if (rec) begin
         if (oe) begin
            dq.push_back(dout);
            oe_cnt++;
         end
         if (done) done_cnt++;
         if (prev_oe && !oe) fall_cnt++;
      end
      prev_oe = oe;
   end

   task automatic rec_start();
      dq.delete();
      oe_cnt = 0; done_cnt = 0; fall_cnt = 0;
      rec = 1'b1;
   endtask

   function automatic logic [63:0] dvec();
      logic [63:0] v = '0;
      foreach (dq[i]) v = {v[62:0], dq[i]};
      return v;
   endfunction

   // Call at posedge+1; returns at posedge+1 of the accepting edge.
   task automatic send(input logic [7:0] d, input logic [7:0] dv, input logic l,
                       input logic il, input logic [1:0] s);
      int k;
      data = d; div = dv; lsb = l; idle = il; ds = s; valid = 1'b1;
      for (k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (ready) break;
      end
      if (k == 5000) chk("send_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int k;
      for (k = 0; k < lim; k++) begin
         @(negedge clk);
         if (!busy && !oe) break;
      end
      if (k == lim) chk("idle_timeout", 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
   endtask

   initial begin
      // Reset with valid and enable high: every output must read 0.
      rst = 1'b1; en = 1'b1; valid = 1'b1; data = 8'hFF; div = 8'd0;
      lsb = 1'b0; idle = 1'b1; ds = 2'b11;
      repeat (3) @(posedge clk); #1;
      chk("rst_oe", oe, 1'b0);
      chk("rst_do", dout, 1'b0);
      chk("rst_ds", dso, 2'b00);
      chk("rst_ready", ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      valid = 1'b0; en = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      en = 1'b1; #1;
      chk("ready_after_rst", ready, 1'b1);
      @(posedge clk); #1;

      // Single frame, DIV=3, LSB first, idle 1, 0xA5.
      rec_start();
      send(8'hA5, 8'd3, 1'b1, 1'b1, 2'b10);
      wait_idle(200);
      rec = 1'b0;
      chk("t2_oe_len", oe_cnt, 36);
      chk("t2_do_seq", dvec(), 36'b11_1111_0000_1111_0000_0000_1111_0000_1111_11);
      chk("t2_done_cnt", done_cnt, 1);
      chk("t2_ds", dso, 2'b10);

      // Back-to-back, DIV=0, MSB first.
      rec_start();
      send(8'h0F, 8'd0, 1'b0, 1'b1, 2'b01);
      send(8'hF0, 8'd0, 1'b0, 1'b1, 2'b01);
      wait_idle(200);
      rec = 1'b0;
      chk("t3_oe_len", oe_cnt, 20);
      chk("t3_do_seq", dvec(), 20'b11_0000111111110000_11);
      chk("t3_oe_falls", fall_cnt, 1);
      chk("t3_done_cnt", done_cnt, 2);

      // Abort during bit 3 (DIV=1: lead c1-2, bit k at c3+2k).
      rec_start();
      send(8'h5A, 8'd1, 1'b1, 1'b0, 2'b11);
      repeat (8) @(posedge clk); #1;
      chk("t4_pre_busy", busy, 1'b1);
      en = 1'b0;
      @(posedge clk); #1;
      chk("t4_oe", oe, 1'b0);
      chk("t4_do", dout, 1'b0);
      chk("t4_busy", busy, 1'b0);
      chk("t4_done", done, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("t4_ready_low", ready, 1'b0);
      end
      rec = 1'b0;
      chk("t4_done_cnt", done_cnt, 0);
      en = 1'b1; #1;
      chk("t4_ready_back", ready, 1'b1);
      @(posedge clk); #1;

      // Async reset mid-lag (DIV=0: lag at c11-12).
      send(8'h33, 8'd0, 1'b1, 1'b1, 2'b01);
      repeat (10) @(posedge clk); #1;
      chk("t5_in_lag", oe, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("t5_oe_async", oe, 1'b0);
      chk("t5_busy_async", busy, 1'b0);
      chk("t5_ds_async", dso, 2'b00);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("t5_ready", ready, 1'b1);

      // Max divider with inputs moving mid-frame.
      rec_start();
      send(8'hC3, 8'hFF, 1'b0, 1'b0, 2'b10);
      div = 8'd0; ds = 2'b01; idle = 1'b1; lsb = 1'b1; data = 8'h00;
      wait_idle(3000);
      rec = 1'b0;
      chk("t6_oe_len", oe_cnt, 2052);
      chk("t6_done_cnt", done_cnt, 1);
      chk("t6_ds", dso, 2'b10);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         rst   = ($urandom_range(0, 599) == 0);
         en    = ($urandom_range(0, 99) != 0);
         valid = $urandom_range(0, 1);
         data  = 8'($urandom);
         div   = 8'($urandom_range(0, 3));
         lsb   = $urandom_range(0, 1);
         idle  = $urandom_range(0, 1);
         ds    = 2'($urandom_range(0, 3));
      end
      @(posedge clk); #1;
      rst = 1'b0; valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
